seq_multiplier: RTL

- Multi-cycle shift-add multiplier: 24-bit x 24-bit operands -> 48-bit product.
- Sits directly upstream of the 48-bit multiply-result register.
- Product drives that register's write data; MulWrite drives its write enable.
- Started by the control unit when a MUL instruction issues; the control unit stalls on Busy.

---
 rtl/seq_multiplier_pkg.sv | 13 +
 rtl/seq_multiplier_if.sv | 26 ++
 rtl/seq_multiplier_twos_abs.sv | 15 +
 rtl/seq_multiplier.sv | 90 +++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared widths and state encoding for the shift-add multiplier
package seq_multiplier_pkg;

   localparam int MUL_WIDTH      = 24;
   localparam int MUL_PROD_WIDTH = 2 * MUL_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - control-unit to multiplier request/result bundle
interface seq_multiplier_if
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);

   logic               Start;
   logic               SignedOp;
   logic [WIDTH-1:0]   OperandA;
   logic [WIDTH-1:0]   OperandB;
   logic               Busy;
   logic [2*WIDTH-1:0] Product;
   logic               MulWrite;

   modport master (
      output Start, SignedOp, OperandA, OperandB,
      input  Busy, Product, MulWrite
   );

   modport slave (
      input  Start, SignedOp, OperandA, OperandB,
      output Busy, Product, MulWrite
   );

endinterface

// File: rtl/seq_multiplier_twos_abs.sv
// rtl/seq_multiplier_twos_abs.sv - conditional two's-complement magnitude
module twos_abs
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  logic             enable,
   output logic [WIDTH-1:0] magnitude
);

   // The most negative input maps to 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit value.
   assign magnitude = (enable && value[WIDTH-1]) ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle shift-add multiplier, one multiplier bit per cycle
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic            Clock,
   input  logic            ResetN,
   seq_multiplier_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mul_state_e       state;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    count;
   logic             neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [PW-1:0]    acc_next;

   twos_abs #(.WIDTH(WIDTH)) u_abs_a (
      .value     (bus.OperandA),
      .enable    (bus.SignedOp),
      .magnitude (mag_a)
   );

   twos_abs #(.WIDTH(WIDTH)) u_abs_b (
      .value     (bus.OperandB),
      .enable    (bus.SignedOp),
      .magnitude (mag_b)
   );

   // The multiplicand register is pre-shifted each cycle, so it always equals |A| << count.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state        <= IDLE;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         count        <= '0;
         neg          <= 1'b0;
         bus.Busy     <= 1'b0;
         bus.Product  <= '0;
         bus.MulWrite <= 1'b0;
      end else begin
         bus.MulWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  mcand    <= {{WIDTH{1'b0}}, mag_a};
                  mplier   <= mag_b;
                  neg      <= bus.SignedOp & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                  acc      <= '0;
                  count    <= '0;
                  bus.Busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               // Final iteration: publish the product so it is valid during the DONE cycle.
               if (count == LAST) begin
                  bus.Product  <= neg ? (~acc_next + 1'b1) : acc_next;
                  bus.MulWrite <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               bus.Busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.Busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
